addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined integer adder/subtractor with valid/ready handshaking, signed/unsigned status flags and optional saturation. It is the successor to the team's 16-bit combinational add/sub unit. Each operand is split into `STAGES` equal slices, with one slice added per cycle and the carry registered between slices. This gives a fixed latency of `STAGES` cycles at full throughput. It sits between the operand-fetch logic and the floating-point adder datapath, where it serves as the mantissa/exponent arithmetic engine.

## Interface
- `WIDTH`, 16: operand/result width in bits. Must be a multiple of `STAGES`.
- `STAGES`, 2: pipeline depth, equal to the number of carry slices. Must be 1..WIDTH.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `dataa`  in  WIDTH  operand A.
- `datab`  in  WIDTH  operand B.
- `add_sub`  in  1  1 = A+B, 0 = A−B.
- `is_signed`  in  1  selects the two's-complement interpretation for overflow and saturation.
- `saturate`  in  1  clamps the result on overflow instead of wrapping.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  sum or difference.
- `carry`  out  1  add: carry-out; sub: borrow (the inverted carry-out).
- `overflow`  out  1  add: carry-out in unsigned mode; sub: borrow in unsigned mode; signed-overflow in signed mode.
- `negative`  out  1  `result[WIDTH-1]`, taken after saturation.
- `zero`  out  1  `result` == 0, taken after saturation.

## Operation
- Subtraction is computed as A + ~B + 1. The +1 enters as the carry-in of slice 0.
- Slice k covers bits [(k+1)·W/S−1 : k·W/S].
- Stage k adds slice k of the operands using the carry registered by stage k−1.
  - Higher, not-yet-added slices of A and B travel alongside in the pipeline registers.
  - Lower, completed slices of the result also travel alongside.
- Mode bits (`add_sub`, `is_signed`, `saturate`) are captured with the operands and travel with the beat.
  - They may change on every accepted beat.
- Raw flags are computed in the final stage:
  - c = carry-out of the top slice.
  - v = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]), where B' = B (add) or ~B (sub).
- Saturation applies only when `saturate` = 1 and overflow is set:
  - Signed: clamp to 0x7F..F if the A sign is 0, otherwise to 0x80..0.
  - Unsigned add: clamp to all-ones.
  - Unsigned sub: clamp to 0.
- `overflow` reports the pre-saturation condition. `carry` always reports the raw c (add) or ~c (sub).
- There is no state machine. Each stage holds a valid bit, and the pipeline is elastic with a global stall:
  - stall = `out_valid` && !`out_ready`.
  - `in_ready` = !stall.
  - When not stalled, every stage advances and bubbles propagate.
  - Bubbles are not collapsed; the pipeline keeps a fixed shape.

## Timing
- Latency: a beat accepted at edge N presents `out_valid` in the cycle after edge N+STAGES−1, i.e. STAGES cycles from acceptance to result.
- Throughput: one beat per cycle while `out_ready` = 1.
- A beat is accepted on the cycle where `in_valid` && `in_ready`. A result is consumed on the cycle where `out_valid` && `out_ready`.
- While stalled:
  - `result` and all flags hold stable.
  - `in_ready` = 0, and inputs are ignored.
- A consume and an accept in the same cycle are legal. Full-rate streaming with no stall has no bubble.
- Reset values: all stage valid bits 0, `out_valid` = 0, `result` = 0, all flags 0, `in_ready` = 1 in the cycle after reset.
- Reset mid-operation discards every in-flight beat. No result for those beats ever appears.
- With `STAGES` = 1, the block degenerates to a single registered full-width add, with latency 1.

## Structure
- Shared package `addsub_pkg`:
  - `addsub_flags_t`, a packed struct of {carry, overflow, negative, zero}.
  - Constants `OP_ADD = 1'b1` and `OP_SUB = 1'b0`.
  - Function `sat_value(width, is_signed, a_sign, add_sub)`.
- Sub-module `addsub_slice`:
  - Parameter: slice width.
  - Inputs: a, b', cin. Outputs: sum, cout, plus the MSB-level signals needed for v.
  - The top level generates `STAGES` instances and the pipeline registers between them.
- Elaboration-time assertion that `WIDTH % STAGES == 0`.

## Test plan
All scenarios use WIDTH=16 and STAGES=2 unless noted.
- **Unsigned add wrap:** 0xFFFF + 0x0001, unsigned, no saturation → after 2 cycles `result` = 0x0000, `carry` = 1, `overflow` = 1, `zero` = 1.
- **Sub borrow:** 0x0005 − 0x0007, signed → `result` = 0xFFFE, `negative` = 1, `carry` (borrow) = 1, `overflow` = 0.
- **Signed saturation:**
  - 0x7FFF + 0x0001, signed, saturate → 0x7FFF, `overflow` = 1.
  - 0x8000 − 0x0001 with the same modes → 0x8000.
  - Unsigned 0x0003 − 0x0004 with saturate → 0x0000, `zero` = 1.
- **Backpressure:**
  - Stream 8 beats with `out_ready` toggling 1,0,0,1… → results arrive in order with no loss or duplication.
  - `result` holds stable while `out_valid` && !`out_ready`.
  - `in_ready` mirrors the stall.
- **Reset mid-flight:** accept 2 beats, assert `reset` for one cycle before they emerge → no `out_valid` for those beats, all outputs 0, next beat returns correctly after 2 cycles.
- **Parameter sweep:** (32,4), (16,1), (8,8) with 1000 random beats and mixed modes compared against a reference model → all results and flags match.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the flag bundle, the operation encodings and the saturation-value helper.
package addsub_pkg;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic negative;
        logic zero;
    } addsub_flags_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    localparam int unsigned MAX_WIDTH = 64;

    // Clamp value for an overflowing operation; the value sits in the low `width` bits.
    function automatic logic [MAX_WIDTH-1:0] sat_value(input int unsigned width,
                                                       input logic        is_signed,
                                                       input logic        a_sign,
                                                       input logic        add_sub);
        logic [MAX_WIDTH-1:0] ones;
        ones = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        if (is_signed) begin
            sat_value = a_sign ? (64'd1 << (width - 1)) : (ones >> 1);
        end else begin
            sat_value = (add_sub == OP_ADD) ? ones : '0;
        end
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry slice of the pipelined adder: sum, carry-out and the slice-level
// two's-complement overflow term (only meaningful for the top slice).
module addsub_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          ovf
);

    logic [SW:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign sum   = total[SW-1:0];
    assign cout  = total[SW];
    assign ovf   = (a[SW-1] == b[SW-1]) && (sum[SW-1] != a[SW-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: one operand slice per stage, carry registered between slices,
// elastic valid/ready with a single global stall; flags and saturation on the output.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             add_sub,
    input  logic             is_signed,
    input  logic             saturate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || WIDTH > int'(MAX_WIDTH))
    begin : g_bad_params
        $error("addsub_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH <= 64");
    end

    // One in-flight beat: operands (b already inverted for subtract), the partial
    // sum built so far, the carry into the next slice and the beat's mode bits.
    typedef struct packed {
        logic             valid;
        logic             add_sub;
        logic             is_signed;
        logic             saturate;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } beat_t;

    beat_t in_beat;
    beat_t stage_d [STAGES];
    beat_t stage_q [STAGES];
    beat_t last;
    logic  stall;

    assign last      = stage_q[STAGES-1];
    assign out_valid = last.valid;
    assign stall     = last.valid && !out_ready;
    assign in_ready  = !stall;

    always_comb begin
        in_beat           = '0;
        in_beat.valid     = in_valid;
        in_beat.add_sub   = add_sub;
        in_beat.is_signed = is_signed;
        in_beat.saturate  = saturate;
        in_beat.a         = dataa;
        in_beat.b         = (add_sub == OP_ADD) ? datab : ~datab;
        in_beat.c         = (add_sub == OP_SUB);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        beat_t         src;
        beat_t         nxt;
        logic [SW-1:0] sl_sum;
        logic          sl_cout;
        logic          sl_ovf;

        if (k == 0) begin : g_first
            assign src = in_beat;
        end else begin : g_next
            assign src = stage_q[k-1];
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a    (src.a[k*SW +: SW]),
            .b    (src.b[k*SW +: SW]),
            .cin  (src.c),
            .sum  (sl_sum),
            .cout (sl_cout),
            .ovf  (sl_ovf)
        );

        always_comb begin
            nxt                 = src;
            nxt.s[k*SW +: SW]   = sl_sum;
            nxt.c               = sl_cout;
            nxt.v               = sl_ovf;
        end

        assign stage_d[k] = nxt;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else if (!stall) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    logic          carry_raw;
    logic          ovf_raw;
    logic [WIDTH-1:0] sat_res;
    logic [WIDTH-1:0] final_res;
    addsub_flags_t flags;

    assign carry_raw = (last.add_sub == OP_ADD) ? last.c : ~last.c;
    assign ovf_raw   = last.is_signed ? last.v : carry_raw;
    assign sat_res   = WIDTH'(sat_value(WIDTH, last.is_signed, last.a[WIDTH-1], last.add_sub));
    assign final_res = (last.saturate && ovf_raw) ? sat_res : last.s;

    // Outputs read as zero whenever no result beat is presented.
    always_comb begin
        flags  = '0;
        result = '0;
        if (last.valid) begin
            result         = final_res;
            flags.carry    = carry_raw;
            flags.overflow = ovf_raw;
            flags.negative = final_res[WIDTH-1];
            flags.zero     = (final_res == '0);
        end
    end

    assign carry    = flags.carry;
    assign overflow = flags.overflow;
    assign negative = flags.negative;
    assign zero     = flags.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed table and corner sequences on a 16/2 instance,
// plus randomized streaming on several geometries against an arithmetic model.
module tb_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- directed instance, WIDTH=16 STAGES=2 ----------------
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] dataa = '0, datab = '0, result;
    logic        add_sub = 1'b1, is_signed = 1'b0, saturate = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic        carry, overflow, negative, zero;

    addsub_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .add_sub(add_sub), .is_signed(is_signed),
        .saturate(saturate), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .negative(negative), .zero(zero)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        op, sgn, sat;
        logic [15:0] res;
        logic        c, v, n, z;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1; dataa = v.a; datab = v.b;
        add_sub = v.op; is_signed = v.sgn; saturate = v.sat; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 64'(seen ? lat : 99), 64'd2);
        chk({nm, " result/flags"}, {result, carry, overflow, negative, zero},
            {v.res, v.c, v.v, v.n, v.z});
    endtask

    // ---------------- randomized sweep instances ----------------
    logic rst_sweep = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : gen_sweep
        localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : (g == 2) ? 8 : 16;
        localparam int S = (g == 0) ? 4  : (g == 1) ? 1  : (g == 2) ? 8 : 2;

        logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
        logic [W-1:0] s_dataa = '0, s_datab = '0, s_result;
        logic         s_add_sub = 1'b1, s_is_signed = 1'b0, s_saturate = 1'b0;
        logic         s_carry, s_overflow, s_negative, s_zero;
        bit           done = 1'b0;

        addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .reset(rst_sweep), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .dataa(s_dataa), .datab(s_datab), .add_sub(s_add_sub), .is_signed(s_is_signed),
            .saturate(s_saturate), .out_valid(s_out_valid), .out_ready(s_out_ready),
            .result(s_result), .carry(s_carry), .overflow(s_overflow),
            .negative(s_negative), .zero(s_zero)
        );

        initial begin
            logic [W+3:0] expq[$];
            logic [W+3:0] exp_v;
            logic [W-1:0] res;
            longint ua, ub, sa, sb, uex, sex, lim;
            logic cy, ovf;
            int sent = 0;
            int budget = 0;
            string tag;
            tag = $sformatf("sweep W%0d S%0d", W, S);
            lim = longint'(1) << W;
            repeat (5) @(negedge clk);
            while ((sent < 1000 || expq.size() != 0) && budget < 20000) begin
                @(negedge clk);
                budget++;
                s_in_valid = (sent < 1000) && ($urandom_range(3) != 0);
                case ($urandom_range(7))
                    0: s_dataa = '0;
                    1: s_dataa = '1;
                    2: s_dataa = {1'b0, {(W-1){1'b1}}};
                    3: s_dataa = {1'b1, {(W-1){1'b0}}};
                    default: s_dataa = W'($urandom);
                endcase
                case ($urandom_range(7))
                    0: s_datab = '0;
                    1: s_datab = '1;
                    2: s_datab = W'(1);
                    3: s_datab = {1'b1, {(W-1){1'b0}}};
                    default: s_datab = W'($urandom);
                endcase
                s_add_sub   = 1'($urandom_range(1));
                s_is_signed = 1'($urandom_range(1));
                s_saturate  = 1'($urandom_range(1));
                s_out_ready = ($urandom_range(3) != 0);
                #1;
                if (s_out_valid && s_out_ready) begin
                    if (expq.size() == 0) begin
                        chk({tag, " unexpected beat"}, 64'd1, 64'd0);
                    end else begin
                        exp_v = expq.pop_front();
                        chk({tag, " result/flags"},
                            64'({s_result, s_carry, s_overflow, s_negative, s_zero}), 64'(exp_v));
                    end
                end
                if (s_in_valid && s_in_ready) begin
                    ua = longint'(s_dataa);
                    ub = longint'(s_datab);
                    sa = s_dataa[W-1] ? ua - lim : ua;
                    sb = s_datab[W-1] ? ub - lim : ub;
                    if (s_add_sub) begin
                        uex = ua + ub; sex = sa + sb; cy = (uex >= lim);
                    end else begin
                        uex = ua - ub; sex = sa - sb; cy = (ua < ub);
                    end
                    res = W'(uex);
                    ovf = s_is_signed ? (sex >= lim / 2 || sex < -(lim / 2)) : cy;
                    if (s_saturate && ovf) begin
                        if (s_is_signed)
                            res = (sex > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
                        else
                            res = s_add_sub ? '1 : '0;
                    end
                    expq.push_back({res, cy, ovf, res[W-1], res == '0});
                    sent++;
                end
            end
            chk({tag, " all beats returned"}, 64'({sent == 1000, expq.size() == 0}), 64'b11);
            s_in_valid = 1'b0;
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        logic [15:0] exp_bp[8];
        logic [15:0] held;
        bit   have_hold;
        int   sent, rcv, extra, seen_v;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'hC000, 16'hC000, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        rst_sweep = 1'b0;
        #1;
        chk("reset state", {out_valid, result, carry, overflow, negative, zero, in_ready},
            {1'b0, 16'h0000, 4'b0000, 1'b1});

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // backpressure: 8 beats, out_ready pattern 1,0,0,1 repeating
        for (int i = 0; i < 8; i++) exp_bp[i] = 16'(i * 16'h1111) + 16'(i + 1);
        sent = 0; rcv = 0; have_hold = 1'b0; held = '0;
        for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            dataa     = 16'(sent * 16'h1111);
            datab     = 16'(sent + 1);
            add_sub = 1'b1; is_signed = 1'b0; saturate = 1'b0;
            #1;
            if (have_hold) begin
                chk("bp hold", {out_valid, result}, {1'b1, held});
                have_hold = 1'b0;
            end
            chk("bp in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                chk($sformatf("bp beat%0d", rcv), result, exp_bp[rcv]);
                rcv++;
            end else if (out_valid) begin
                have_hold = 1'b1;
                held      = result;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp beats received", 64'(rcv), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        chk("bp no duplicates", 64'(extra), 64'd0);

        // reset mid-flight: one beat accepted, second presented with reset
        @(negedge clk);
        in_valid = 1'b1; dataa = 16'h1234; datab = 16'h1111; add_sub = 1'b1;
        is_signed = 1'b0; saturate = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dataa = 16'h2222; datab = 16'h0001; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("post-reset outputs", {out_valid, result, carry, overflow, negative, zero, in_ready},
            {1'b0, 16'h0000, 4'b0000, 1'b1});
        seen_v = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) seen_v++;
        end
        chk("flushed beats absent", 64'(seen_v), 64'd0);
        run_vec('{16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0},
                "after reset");

        begin
            bit all_done;
            all_done = 1'b0;
            for (int t = 0; t < 40000; t++) begin
                all_done = gen_sweep[0].done && gen_sweep[1].done &&
                           gen_sweep[2].done && gen_sweep[3].done;
                if (all_done) break;
                @(negedge clk);
            end
            chk("sweep completion", 64'(all_done), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
